// File: rtl/reg_cpu_if.sv
// reg_cpu register bus: initiator drives the request, responder returns wack/rdv pulses.
interface reg_cpu_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          cs;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_wr;
  logic          we;
  logic          re;
  logic [DW-1:0] data_rd;
  logic          wack;
  logic          rdv;

  modport master (
    output cs, addr, data_wr, we, re,
    input  data_rd, wack, rdv
  );

  modport slave (
    input  cs, addr, data_wr, we, re,
    output data_rd, wack, rdv
  );
endinterface

// File: rtl/reg_cpu_slave.sv
// reg_cpu bus responder: decodes requests into the image-pipe config/status register bank.
// Flow: IDLE captures a request, WAIT burns WAIT_CYCLES, RESP commits/samples,
// RECOV carries the one-cycle wack/rdv pulse and ignores the bus.
module reg_cpu_slave #(
  parameter int unsigned   AW          = 32,
  parameter int unsigned   DW          = 32,
  parameter int unsigned   WAIT_CYCLES = 1,
  parameter logic [AW-1:0] BASE_ADDR   = '0
) (
  input  logic        reg_cpu_clk,
  input  logic        rst_n,
  reg_cpu_if.slave    bus,
  output logic        cfg_enable,
  output logic [15:0] cfg_width,
  output logic [15:0] cfg_height,
  input  logic        sts_busy,
  input  logic [15:0] sts_frame_cnt,
  input  logic        irq_frame_done,
  output logic        irq
);

  localparam logic [3:0]  WaitLast    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] ImgSizeRst  = 32'h01E0_0280;

  typedef enum logic [1:0] {StIdle, StWait, StResp, StRecov} state_e;
  typedef enum logic [2:0] {SelCtrl, SelStatus, SelImg, SelIrq, SelScratch, SelNone} sel_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          capture;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          op_we_q;

  logic          wack_q;
  logic          rdv_q;
  logic [DW-1:0] data_rd_q;

  logic [1:0]    ctrl_q;
  logic [31:0]   img_size_q;
  logic          irq_sts_q;
  logic [31:0]   scratch_q;
  logic          irq_q;

  logic [AW-1:0] offset;
  logic          unused_addr_bits;
  sel_e          sel;
  logic [31:0]   rd_val;
  logic          resp;
  logic          wr_commit;
  logic          irq_clr;

  // Next-state logic of the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cs && (bus.we || bus.re)) begin
          capture = 1'b1;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StRecov;
      StRecov: state_d = StIdle;
    endcase
  end

  // Sequencer state and captured request; bus inputs are ignored once captured.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.data_wr;
        // Write wins when both we and re are set.
        op_we_q <= bus.we;
      end
    end
  end

  assign offset           = addr_q - BASE_ADDR;
  assign unused_addr_bits = ^offset[1:0];
  assign resp             = (state_q == StResp);
  assign wr_commit        = resp && op_we_q;

  // Address decode of the captured request; anything outside the five words is unmapped.
  always_comb begin
    sel = SelNone;
    if (offset[AW-1:5] == '0) begin
      case (offset[4:2])
        3'd0:    sel = SelCtrl;
        3'd1:    sel = SelStatus;
        3'd2:    sel = SelImg;
        3'd3:    sel = SelIrq;
        3'd4:    sel = SelScratch;
        default: sel = SelNone;
      endcase
    end
  end

  // Read mux; unmapped reads return zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      SelCtrl:    rd_val = {30'b0, ctrl_q};
      SelStatus:  rd_val = {15'b0, sts_busy, sts_frame_cnt};
      SelImg:     rd_val = img_size_q;
      SelIrq:     rd_val = {31'b0, irq_sts_q};
      SelScratch: rd_val = scratch_q;
      default:    rd_val = '0;
    endcase
  end

  assign irq_clr = wr_commit && (sel == SelIrq) && wdata_q[0];

  // Response pulses: raised at the RESP edge, dropped one cycle later with data cleared.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      wack_q    <= 1'b0;
      rdv_q     <= 1'b0;
      data_rd_q <= '0;
    end else begin
      wack_q    <= wr_commit;
      rdv_q     <= resp && !op_we_q;
      data_rd_q <= (resp && !op_we_q) ? DW'(rd_val) : '0;
    end
  end

  // Register bank; writes commit on the same edge that raises wack.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= 2'b00;
      img_size_q <= ImgSizeRst;
      scratch_q  <= '0;
    end else if (wr_commit) begin
      case (sel)
        SelCtrl:    ctrl_q     <= wdata_q[1:0];
        SelImg:     img_size_q <= wdata_q[31:0];
        SelScratch: scratch_q  <= wdata_q[31:0];
        default:    ;
      endcase
    end
  end

  // Frame-done status: a new pulse beats a simultaneous W1C clear.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sts_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_sts_q <= irq_frame_done || (irq_sts_q && !irq_clr);
      irq_q     <= irq_sts_q && ctrl_q[1];
    end
  end

  assign bus.wack    = wack_q;
  assign bus.rdv     = rdv_q;
  assign bus.data_rd = data_rd_q;
  assign cfg_enable  = ctrl_q[0];
  assign cfg_width   = img_size_q[15:0];
  assign cfg_height  = img_size_q[31:16];
  assign irq         = irq_q;

endmodule

// File: tb/tb_reg_cpu_slave.sv
// Directed bench for reg_cpu_slave with WAIT_CYCLES=1 (response two cycles after the request edge).
module tb_reg_cpu_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic        sts_busy;
  logic [15:0] sts_frame_cnt;
  logic        irq_frame_done;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  reg_cpu_if #(.AW(32), .DW(32)) bus ();

  reg_cpu_slave #(
    .AW(32), .DW(32), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)
  ) dut (
    .reg_cpu_clk    (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cfg_enable     (cfg_enable),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .sts_busy       (sts_busy),
    .sts_frame_cnt  (sts_frame_cnt),
    .irq_frame_done (irq_frame_done),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transaction; request inputs are scrambled right after capture.
  // pulse=1 raises irq_frame_done across the commit edge.
  task automatic xfer(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic pulse,
                      output logic [31:0] rdata, output logic got_wack, output logic got_rdv);
    int lat;
    lat      = 99;
    got_wack = 1'b0;
    got_rdv  = 1'b0;
    rdata    = '0;
    @(negedge clk);
    bus.cs = 1'b1; bus.we = we; bus.re = re; bus.addr = addr; bus.data_wr = wdata;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 32'hFFFF_FFF0; bus.data_wr = ~wdata;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      irq_frame_done = pulse && (i == 2);
      @(posedge clk); #1;
      if (bus.wack || bus.rdv) begin
        lat      = i;
        got_wack = bus.wack;
        got_rdv  = bus.rdv;
        rdata    = bus.data_rd;
        break;
      end
    end
    irq_frame_done = 1'b0;
    check("latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    check("pulse_end", 32'({bus.wack, bus.rdv, |bus.data_rd}), 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] d;
    logic        a, v;
    xfer(1'b1, 1'b0, addr, wdata, 1'b0, d, a, v);
    check({tag, "_ack"}, 32'({a, v}), 32'b10);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic        a, v;
    xfer(1'b0, 1'b1, addr, 32'h0, 1'b0, d, a, v);
    check({tag, "_ack"}, 32'({a, v}), 32'b01);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        a, v;
    rst_n = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.data_wr = '0;
    sts_busy = 1'b0; sts_frame_cnt = '0; irq_frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'({bus.wack, bus.rdv, irq, cfg_enable}), 32'd0);
    check("rst_data_rd", bus.data_rd, 32'd0);
    check("rst_size", {cfg_height, cfg_width}, 32'h01E0_0280);
    @(negedge clk);
    rst_n = 1'b1;

    rd(32'h08, 32'h01E0_0280, "rd_img_rst");
    rd(32'h00, 32'h0, "rd_ctrl_rst");

    wr(32'h00, 32'hFFFF_FFFF, "wr_ctrl_ff");
    check("cfg_enable_1", 32'(cfg_enable), 32'd1);
    rd(32'h00, 32'h3, "rd_ctrl_3");

    wr(32'h08, 32'h0438_0780, "wr_img");
    check("cfg_width", 32'(cfg_width), 32'h0780);
    check("cfg_height", 32'(cfg_height), 32'h0438);
    wr(32'h10, 32'hA5A5_5A5A, "wr_scratch");
    rd(32'h10, 32'hA5A5_5A5A, "rd_scratch");

    wr(32'h00, 32'h2, "wr_ctrl_2");
    check("cfg_enable_0", 32'(cfg_enable), 32'd0);
    check("irq_idle", 32'(irq), 32'd0);
    @(negedge clk); irq_frame_done = 1'b1;
    @(negedge clk); irq_frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("irq_set", 32'(irq), 32'd1);
    rd(32'h0C, 32'h1, "rd_irqsts_1");
    xfer(1'b1, 1'b0, 32'h0C, 32'h1, 1'b1, d, a, v);
    check("w1c_race_ack", 32'({a, v}), 32'b10);
    check("irq_race", 32'(irq), 32'd1);
    rd(32'h0C, 32'h1, "rd_irqsts_race");
    wr(32'h0C, 32'h1, "wr_w1c");
    check("irq_cleared", 32'(irq), 32'd0);
    rd(32'h0C, 32'h0, "rd_irqsts_0");

    sts_busy = 1'b1; sts_frame_cnt = 16'h0123;
    rd(32'h04, 32'h0001_0123, "rd_status");
    rd(32'h40, 32'h0, "rd_unmapped");
    rd(32'h14, 32'h0, "rd_hole");
    wr(32'h40, 32'hDEAD_BEEF, "wr_unmapped");
    rd(32'h10, 32'hA5A5_5A5A, "rd_scratch_keep");
    rd(32'h00, 32'h2, "rd_ctrl_keep");
    rd(32'h08, 32'h0438_0780, "rd_img_keep");

    xfer(1'b1, 1'b1, 32'h10, 32'h1111_2222, 1'b0, d, a, v);
    check("we_re_ack", 32'({a, v}), 32'b10);
    rd(32'h10, 32'h1111_2222, "rd_we_re");

    // Reset lands while a write of IMG_SIZE sits in WAIT.
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.addr = 32'h08; bus.data_wr = 32'h1234_5678;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({bus.wack, bus.rdv, irq, cfg_enable}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_ack", 32'({bus.wack, bus.rdv}), 32'd0);
    end
    check("midrst_size", {cfg_height, cfg_width}, 32'h01E0_0280);
    rd(32'h08, 32'h01E0_0280, "rd_img_after_rst");
    rd(32'h10, 32'h0, "rd_scratch_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_cpu_slave.md
Name: reg_cpu_slave

Overview:
- Responder end of the reg_cpu register bus. Decodes CPU read and write requests into a small image-pipe configuration/status register bank.
- Returns reg_cpu_wack for writes and reg_cpu_rdv with reg_cpu_data_rd for reads, after a programmable number of wait states.
- Sits between the CPU/testbench bus initiator and the image pipe datapath. Drives its config outputs and collects its status and interrupt inputs.

Parameters:
- AW, 32, address width.
- DW, 32, data width (register map defined for 32).
- WAIT_CYCLES, 1, wait states between request capture and response (legal 0..15).
- BASE_ADDR, 32'h0, base of the register window.

Ports:
- reg_cpu_clk  in  1  bus/register clock
- rst_n  in  1  reset
- reg_cpu_cs  in  1  chip select
- reg_cpu_addr  in  AW  byte address
- reg_cpu_data_wr  in  DW  write data
- reg_cpu_we  in  1  write request
- reg_cpu_re  in  1  read request
- reg_cpu_data_rd  out  DW  read data, valid with rdv
- reg_cpu_wack  out  1  write acknowledge, 1-cycle pulse
- reg_cpu_rdv  out  1  read data valid, 1-cycle pulse
- cfg_enable  out  1  CTRL[0]
- cfg_width  out  16  IMG_SIZE[15:0]
- cfg_height  out  16  IMG_SIZE[31:16]
- sts_busy  in  1  pipe busy
- sts_frame_cnt  in  16  frame counter
- irq_frame_done  in  1  1-cycle frame-done pulse
- irq  out  1  level interrupt

Behaviour:
- One clock, reg_cpu_clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - wack, rdv, irq, cfg_enable = 0; data_rd = 0.
  - CTRL = 0; IMG_SIZE = 32'h01E0_0280 (w=640, h=480); IRQ_STS = 0; SCRATCH = 0.
  - FSM = IDLE.
- Register map (offset from BASE_ADDR, word aligned; addr[1:0] ignored):
  - 0x00 CTRL, RW, bits[1:0]: bit0 enable, bit1 irq_en; other bits read 0.
  - 0x04 STATUS, RO: {15'b0, sts_busy, sts_frame_cnt}.
  - 0x08 IMG_SIZE, RW, all 32 bits.
  - 0x0C IRQ_STS, W1C, bit0 frame_done.
  - 0x10 SCRATCH, RW, all 32 bits.
- Any other address inside or outside the window is unmapped:
  - Writes are acked and have no effect.
  - Reads are acked with data 0.
- FSM states: IDLE, WAIT, RESP, RECOV.
  - IDLE: on a posedge with cs=1 and (we|re)=1, capture addr, data_wr and op (we has priority if both we and re are 1).
    - Go to WAIT if WAIT_CYCLES>0, else RESP.
    - cs=0, or cs=1 with we=re=0: stay in IDLE.
  - WAIT: 4-bit counter counts WAIT_CYCLES cycles, then go to RESP. Bus inputs are ignored.
  - RESP: one cycle.
    - Write: wack=1; the register update is committed at the same edge wack rises and is visible from the next cycle.
    - Read: rdv=1; data_rd = register value sampled at RESP entry. data_rd returns to 0 when rdv falls.
    - Go to RECOV.
  - RECOV: one cycle, requests ignored, then go to IDLE. The initiator must drop cs/we/re by then.
- Latency: request edge to response pulse = WAIT_CYCLES+1 cycles. Back-to-back request throughput = one per WAIT_CYCLES+3 cycles.
- IRQ_STS[0]:
  - Set by irq_frame_done.
  - Cleared by a write with data_wr[0]=1 to 0x0C.
  - Set and clear in the same cycle: set wins.
  - irq = IRQ_STS[0] & CTRL[1], registered (1-cycle delay after the status change).
- Captured address and data are used throughout the transaction. Input changes after capture have no effect.
- Reset asserted mid-transaction: immediate return to IDLE; no pending write is committed; all outputs go to reset values.

Test Plan:
- Reset, then read 0x08 with WAIT_CYCLES=1 -> rdv pulse 2 cycles after the request edge, data_rd=32'h01E0_0280; read 0x00 -> 0.
- Write 0x00 = 32'hFFFF_FFFF -> wack after 2 cycles, cfg_enable=1 the next cycle; readback = 32'h3.
- Write 0x08 = 32'h0438_0780 -> cfg_width=16'h0780, cfg_height=16'h0438; write SCRATCH = 32'hA5A5_5A5A, read back equal.
- CTRL=2, pulse irq_frame_done -> IRQ_STS=1, irq=1. Write 0x0C=1 in the same cycle as another irq_frame_done pulse -> bit stays 1. A later W1C without a pulse -> irq=0.
- Read 0x04 with sts_busy=1, sts_frame_cnt=16'h0123 -> data_rd=32'h0001_0123. Read 0x40 -> rdv with data 0. Write 0x40 -> wack, no register changes.
- Assert rst_n low while in WAIT on a write of 0x08 -> no wack, IMG_SIZE stays 32'h01E0_0280. Request with we=re=1 -> treated as a write (wack, no rdv).
